// File: rtl/hbridge_pwm_apb.sv
// APB3 slave driving NUM_CH dead-time-protected H-bridge PWM channels from one shared counter.
// Optional capture/interrupt block is built only when HBRIDGE_CAPTURE_EN is defined.
module hbridge_pwm_apb #(
    parameter int NUM_CH      = 2,
    parameter int PWM_WIDTH   = 16,
    parameter int DEAD_CYCLES = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [7:0]            PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic                  CAPTURE_SWITCH,
    output logic                  FABINT,
    output logic [NUM_CH-1:0]     PWM,
    output logic [2*NUM_CH-1:0]   H_IN
);

    localparam logic [8:0] ADDR_END = 9'(16 + 8 * NUM_CH);

    logic                 gen, int_en;
    logic [PWM_WIDTH-1:0] per_s, per_a, cnt;
    logic [PWM_WIDTH-1:0] duty_s [NUM_CH];
    logic [PWM_WIDTH-1:0] duty_a [NUM_CH];
    logic [NUM_CH-1:0]    ch_en, ch_dir, ch_brk;
    logic [7:0]           dead [NUM_CH];

    logic                 wr_en, addr_ok, wrap;
    logic [NUM_CH-1:0]    duty_hit, ctl_hit, dir_chg, pwm_n;
    logic [2*NUM_CH-1:0]  legs_n;
    logic                 pend;
    logic [31:0]          cap;
    logic                 unused_sink;

    assign wr_en   = PSEL & PENABLE & PWRITE;
    assign addr_ok = (PADDR[1:0] == 2'b00) && ({1'b0, PADDR} < ADDR_END);
    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL & PENABLE & ~addr_ok;
    assign wrap    = (cnt == per_a);

    always_comb begin
        duty_hit = '0;
        ctl_hit  = '0;
        dir_chg  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            duty_hit[c] = (PADDR == 8'(16 + 8 * c));
            ctl_hit[c]  = (PADDR == 8'(20 + 8 * c));
            // A reversal only needs dead time if the channel stays enabled across it.
            dir_chg[c]  = wr_en & ctl_hit[c] & ch_en[c] & PWDATA[0] & (PWDATA[1] != ch_dir[c]);
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && PENABLE && !PWRITE && addr_ok) begin
            if (PADDR == 8'h00) PRDATA[1:0] = {int_en, gen};
            if (PADDR == 8'h04) PRDATA[PWM_WIDTH-1:0] = per_s;
            if (PADDR == 8'h08) PRDATA[0] = pend;
            if (PADDR == 8'h0C) PRDATA = cap;
            for (int c = 0; c < NUM_CH; c++) begin
                if (duty_hit[c]) PRDATA[PWM_WIDTH-1:0] = duty_s[c];
                if (ctl_hit[c])  PRDATA[2:0] = {ch_brk[c], ch_dir[c], ch_en[c]};
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            gen    <= 1'b0;
            int_en <= 1'b0;
            per_s  <= '0;
            ch_en  <= '0;
            ch_dir <= '0;
            ch_brk <= '0;
            for (int c = 0; c < NUM_CH; c++) duty_s[c] <= '0;
        end else begin
            if (wr_en && PADDR == 8'h00) {int_en, gen} <= PWDATA[1:0];
            if (wr_en && PADDR == 8'h04) per_s <= PWDATA[PWM_WIDTH-1:0];
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_en && duty_hit[c]) duty_s[c] <= PWDATA[PWM_WIDTH-1:0];
                if (wr_en && ctl_hit[c]) begin
                    ch_en[c]  <= PWDATA[0];
                    ch_dir[c] <= PWDATA[1];
                    ch_brk[c] <= PWDATA[2];
                end
            end
        end
    end

    // Shadows move to active at the wrap so a period is never emitted half-old, half-new.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt   <= '0;
            per_a <= '0;
            for (int c = 0; c < NUM_CH; c++) duty_a[c] <= '0;
        end else begin
            if (!gen || wrap) cnt <= '0;
            else              cnt <= cnt + 1'b1;
            if (!gen || wrap) begin
                per_a <= per_s;
                for (int c = 0; c < NUM_CH; c++) duty_a[c] <= duty_s[c];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int c = 0; c < NUM_CH; c++) dead[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (dir_chg[c])                  dead[c] <= 8'(DEAD_CYCLES);
                else if (ch_brk[c] || !ch_en[c]) dead[c] <= '0;
                else if (dead[c] != 8'd0)        dead[c] <= dead[c] - 1'b1;
            end
        end
    end

    always_comb begin
        pwm_n  = '0;
        legs_n = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pwm_n[c] = ch_en[c] & gen & (cnt < duty_a[c]);
            if (ch_en[c]) begin
                if (ch_brk[c])             legs_n[2*c +: 2] = 2'b11;
                else if (dead[c] == 8'd0)  legs_n[2*c +: 2] = ch_dir[c] ? {pwm_n[c], 1'b0}
                                                                        : {1'b0, pwm_n[c]};
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PWM  <= '0;
            H_IN <= '0;
        end else begin
            PWM  <= pwm_n;
            H_IN <= legs_n;
        end
    end

`ifdef HBRIDGE_CAPTURE_EN
    logic [2:0]  sync;
    logic [31:0] ts;
    logic        rise, w1c;

    assign rise   = sync[1] & ~sync[2];
    assign w1c    = wr_en && (PADDR == 8'h08) && PWDATA[0];
    assign FABINT = pend & int_en;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync <= '0;
            ts   <= '0;
            cap  <= '0;
            pend <= 1'b0;
        end else begin
            sync <= {sync[1:0], CAPTURE_SWITCH};
            ts   <= ts + 1'b1;
            if (rise) cap <= ts;
            // A new edge in the same cycle as a clear must not be lost.
            if (rise)     pend <= 1'b1;
            else if (w1c) pend <= 1'b0;
        end
    end

    assign unused_sink = ^PWDATA;
`else
    assign pend        = 1'b0;
    assign cap         = '0;
    assign FABINT      = 1'b0;
    assign unused_sink = ^{PWDATA, CAPTURE_SWITCH, int_en};
`endif

endmodule

// File: tb/tb_hbridge_pwm_apb.sv
// Directed bench for hbridge_pwm_apb: PWM duty/shadowing, dead time, brake, APB errors, reset.
// Capture checks are compiled in only when HBRIDGE_CAPTURE_EN is defined.
module tb_hbridge_pwm_apb;
    localparam int NUM_CH      = 2;
    localparam int PWM_WIDTH   = 16;
    localparam int DEAD_CYCLES = 8;

    logic                PCLK = 1'b0;
    logic                PRESET = 1'b1;
    logic                PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0]          PADDR = '0;
    logic [31:0]         PWDATA = '0;
    logic [31:0]         PRDATA;
    logic                PREADY, PSLVERR;
    logic                CAPTURE_SWITCH = 1'b0;
    logic                FABINT;
    logic [NUM_CH-1:0]   PWM;
    logic [2*NUM_CH-1:0] H_IN;

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_q[$];

    hbridge_pwm_apb #(.NUM_CH(NUM_CH), .PWM_WIDTH(PWM_WIDTH), .DEAD_CYCLES(DEAD_CYCLES)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .CAPTURE_SWITCH(CAPTURE_SWITCH), .FABINT(FABINT), .PWM(PWM), .H_IN(H_IN)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1;
        data = PRDATA;
        err  = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Syncs to a PWM[0] rising edge, then returns the high run and following low run.
    task automatic measure_runs(output int hi, output int lo);
        int guard = 0;
        while (PWM[0] !== 1'b0 && guard < 50)  begin tick(); guard++; end
        while (PWM[0] !== 1'b1 && guard < 100) begin tick(); guard++; end
        hi = 0;
        while (PWM[0] === 1'b1 && guard < 150) begin hi++; tick(); guard++; end
        lo = 0;
        while (PWM[0] === 1'b0 && guard < 200) begin lo++; tick(); guard++; end
        check("measure_bound", 32'(guard < 200), 32'd1);
    endtask

    task automatic check_queue(input string tag);
        int i = 0;
        while (exp_q.size() > 0) begin
            tick();
            check($sformatf("%s_%0d", tag, i), 32'(H_IN[1:0]), 32'(exp_q.pop_front()));
            i++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          hi, lo, cnt_hi, errs;

        tick(3);
        check("rst_pwm", 32'(PWM), 32'd0);
        check("rst_hin", 32'(H_IN), 32'd0);
        check("rst_fabint", 32'(FABINT), 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        PRESET = 1'b0;
        tick();
        apb_read(8'h00, rd, err);
        check("rst_ctrl", rd, 32'd0);

        // Basic forward PWM: PERIOD=9, DUTY0=3
        apb_write(8'h04, 32'd9);
        apb_write(8'h10, 32'd3);
        apb_write(8'h14, 32'd1);
        apb_write(8'h00, 32'd1);
        apb_read(8'h04, rd, err);
        check("rd_period", rd, 32'd9);
        apb_read(8'h10, rd, err);
        check("rd_duty0", rd, 32'd3);
        tick(3);
        errs = 0; cnt_hi = 0;
        repeat (20) begin
            tick();
            if (H_IN[0] !== PWM[0] || H_IN[1] !== 1'b0 || PWM[1] !== 1'b0 || H_IN[3:2] !== 2'b00) errs++;
            cnt_hi += int'(PWM[0]);
        end
        check("fwd_legs", 32'(errs), 32'd0);
        check("duty3_count", 32'(cnt_hi), 32'd6);
        measure_runs(hi, lo);
        check("duty3_hi", 32'(hi), 32'd3);
        check("duty3_lo", 32'(lo), 32'd7);

        // Mid-period duty change: old duty held until the wrap
        apb_write(8'h10, 32'd7);
        check("old_duty_held", 32'(PWM[0]), 32'd0);
        measure_runs(hi, lo);
        check("duty7_hi", 32'(hi), 32'd7);
        check("duty7_lo", 32'(lo), 32'd3);

        // fwd -> rev: eight dead cycles, then leg B carries PWM
        apb_write(8'h14, 32'd3);
        repeat (DEAD_CYCLES) exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
        check_queue("dead_rev");
        apb_read(8'h14, rd, err);
        check("rd_chctrl0", rd, 32'd3);

        // Brake during dead time takes effect on the next cycle
        apb_write(8'h14, 32'd1);
        apb_write(8'h14, 32'd5);
        check("dead_before_brake", 32'(H_IN[1:0]), 32'd0);
        tick();
        check("brake", 32'(H_IN[1:0]), 32'd3);

        // DUTY > PERIOD is 100 %
        apb_write(8'h10, 32'd12);
        tick(12);
        apb_write(8'h14, 32'd1);
        tick(2);
        errs = 0; cnt_hi = 0;
        repeat (20) begin
            tick();
            if (H_IN[1:0] !== 2'b01) errs++;
            cnt_hi += int'(PWM[0]);
        end
        check("full_count", 32'(cnt_hi), 32'd20);
        check("full_legs", 32'(errs), 32'd0);

        // A second direction change during dead time restarts the count
        apb_write(8'h14, 32'd3);
        apb_write(8'h14, 32'd1);
        check("restart_dead_start", 32'(H_IN[1:0]), 32'd0);
        repeat (DEAD_CYCLES) exp_q.push_back(2'b00);
        exp_q.push_back(2'b01);
        check_queue("dead_restart");

        // DUTY=0 is 0 %
        apb_write(8'h10, 32'd0);
        tick(12);
        cnt_hi = 0;
        repeat (20) begin tick(); cnt_hi += int'(PWM[0]) + int'(H_IN[0]); end
        check("zero_count", 32'(cnt_hi), 32'd0);

        // PERIOD=0, DUTY=1: constantly high; global disable holds outputs low
        apb_write(8'h00, 32'd0);
        apb_write(8'h04, 32'd0);
        apb_write(8'h10, 32'd1);
        check("gen_off_pwm", 32'(PWM), 32'd0);
        apb_write(8'h00, 32'd1);
        tick(2);
        cnt_hi = 0;
        repeat (20) begin tick(); cnt_hi += int'(PWM[0]); end
        check("period0_count", 32'(cnt_hi), 32'd20);

        // Unused CTRL bits read 0
        apb_write(8'h00, 32'hFFFF_FFFF);
        apb_read(8'h00, rd, err);
        check("ctrl_unused_bits", rd, 32'd3);
        apb_write(8'h00, 32'd1);

        // Address errors
        apb_read(8'h24, rd, err);
        check("err_0x24_flag", 32'(err), 32'd1);
        check("err_0x24_data", rd, 32'd0);
        apb_read(8'h06, rd, err);
        check("err_unaligned", 32'(err), 32'd1);
        apb_write(8'h1C, 32'd7);
        apb_read(8'h1C, rd, err);
        check("chctrl1_flag", 32'(err), 32'd0);
        check("chctrl1_data", rd, 32'd7);
        apb_write(8'h1C, 32'd0);

`ifdef HBRIDGE_CAPTURE_EN
        begin
            logic [31:0] cap1;
            apb_write(8'h00, 32'd3);
            tick(4);
            CAPTURE_SWITCH = 1'b1;
            tick(2);
            check("cap_not_yet", 32'(FABINT), 32'd0);
            tick();
            check("cap_fabint", 32'(FABINT), 32'd1);
            apb_read(8'h08, rd, err);
            check("cap_status", rd, 32'd1);
            apb_read(8'h0C, cap1, err);
            check("cap_nonzero", 32'(cap1 != 32'd0), 32'd1);
            apb_write(8'h08, 32'd1);
            check("cap_w1c", 32'(FABINT), 32'd0);
            CAPTURE_SWITCH = 1'b0;
            tick(4);
            CAPTURE_SWITCH = 1'b1;
            tick(4);
            CAPTURE_SWITCH = 1'b0;
            tick(4);
            CAPTURE_SWITCH = 1'b1;
            apb_write(8'h08, 32'd1);
            check("cap_set_wins", 32'(FABINT), 32'd1);
            apb_read(8'h0C, rd, err);
            check("cap_overwrite", 32'(rd > cap1), 32'd1);
        end
`else
        apb_read(8'h08, rd, err);
        check("status_off_data", rd, 32'd0);
        check("status_off_flag", 32'(err), 32'd0);
        CAPTURE_SWITCH = 1'b1;
        tick(5);
        check("fabint_off", 32'(FABINT), 32'd0);
`endif

        // Reset during active PWM: outputs low after the next edge
        check("pre_reset_pwm", 32'(PWM[0]), 32'd1);
        PRESET = 1'b1;
        tick();
        check("reset_pwm", 32'(PWM), 32'd0);
        check("reset_hin", 32'(H_IN), 32'd0);
        PRESET = 1'b0;
        apb_read(8'h04, rd, err);
        check("reset_period", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hbridge_pwm_apb.md
# hbridge_pwm_apb

APB3 slave driving NUM_CH independent H-bridge channels, each with its own PWM duty, direction, brake and dead-time-protected reversal, plus a timestamped capture input that raises a fabric interrupt. Sits in slot 0 behind the CoreAPB3 bus from the MSS master APB. It is the generalisation of the single-PWM, four-pin controller to N channels with configurable counter width.

## Interface
- NUM_CH, 2, channel count (1..8)
- PWM_WIDTH, 16, PWM counter/period/duty width (8..32)
- DEAD_CYCLES, 8, PCLK cycles both legs low on direction change (1..255)
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset; synchronous and active-high
- PSEL, PENABLE, PWRITE  in  1  APB3 control
- PADDR  in  8  byte address, word aligned
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  constant 1 (no wait states)
- PSLVERR  out  1  error on unmapped address
- CAPTURE_SWITCH  in  1  asynchronous capture input
- FABINT  out  1  interrupt to MSS
- PWM  out  NUM_CH  raw PWM per channel
- H_IN  out  2*NUM_CH  bridge inputs; H_IN[2c]=leg A, H_IN[2c+1]=leg B of channel c

## Operation
- Registers: 0x00 CTRL (b0 global enable, b1 int enable); 0x04 PERIOD; 0x08 STATUS (b0 capture pending, W1C); 0x0C CAPTURE (RO); 0x10+8c DUTY[c]; 0x14+8c CHCTRL[c] (b0 enable, b1 dir 0=fwd/1=rev, b2 brake). Unused bits read 0, ignore writes.
- PSLVERR=1 in access phase for address beyond last channel or non-aligned; such writes have no effect, reads return 0.
- Shared counter cnt counts 0..PERIOD_active, wraps to 0. Global enable 0: cnt held at 0.
- PERIOD and DUTY writes go to shadow registers; copied to active at wrap (cnt==PERIOD_active) or while global enable is 0.
- pwm[c] = channel enable & global enable & (cnt < DUTY_active[c]). DUTY > PERIOD gives 100 %; DUTY=0 gives 0 %. PERIOD=0: cnt stays 0, pwm high iff DUTY≠0.
- Per-channel legs: disabled → A=0,B=0; brake (priority over PWM, requires enable) → A=1,B=1; fwd → A=pwm,B=0; rev → A=0,B=pwm.
- Direction change on an enabled channel: both legs 0 for DEAD_CYCLES cycles, then new direction applies. Another change during dead time restarts the count. Brake during dead time takes effect immediately and aborts dead time.
- Capture: CAPTURE_SWITCH through 2-flop synchroniser; rising edge latches free-running 32-bit timestamp into CAPTURE (wraps at 2^32) and sets pending. Edges while pending set overwrite CAPTURE. FABINT = pending & int enable.
- Pending set and W1C in same cycle: set wins.

## Timing
- Reset: all registers 0, cnt 0, timestamp 0, dead-time counters 0, PRDATA 0, PSLVERR 0, FABINT 0, PWM 0, H_IN 0.
- APB: writes commit on PSEL&PENABLE&PWRITE rising edge; PRDATA combinational in access phase; PREADY always 1.
- PWM and H_IN registered: change one cycle after cnt/active-register change.
- Shadow update visible at the first cycle of the next period.
- Capture latency: edge on CAPTURE_SWITCH → CAPTURE/pending updated 3 cycles later; FABINT same cycle as pending.
- PRESET mid-period or mid-dead-time: all outputs 0 next edge; no partial period emitted.

## Configuration
- HBRIDGE_CAPTURE_EN defined: synchroniser, timestamp counter, CAPTURE and STATUS logic built.
- Undefined: 0x08 and 0x0C read 0, writes ignored, no PSLVERR; FABINT tied 0; CAPTURE_SWITCH unused.

## Test plan
- NUM_CH=2, PERIOD=9, DUTY0=3, ch0 fwd enabled, global enable → PWM[0] high 3 of every 10 cycles, H_IN[0]=PWM[0], H_IN[1]=0.
- Mid-period write DUTY0=7 → old duty held until wrap; next period high for 7 cycles.
- Ch0 fwd→rev with DEAD_CYCLES=8 → H_IN[1:0]=00 exactly 8 cycles, then H_IN[1] pulses; brake written during dead time → H_IN[1:0]=11 next cycle.
- DUTY=12, PERIOD=9 → PWM constantly 1; DUTY=0 → constantly 0; PERIOD=0, DUTY=1 → constantly 1.
- Int enable, CAPTURE_SWITCH rising at timestamp T → CAPTURE=T+3-based value, FABINT=1; W1C STATUS coincident with new edge → pending stays 1.
- Read 0x24 with NUM_CH=2 → PSLVERR=1, PRDATA=0; PRESET during active PWM → all outputs 0 next edge.
